// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC and drives a stallable instruction-fetch handshake.
// Optional misaligned-branch trap is enabled by defining PC_ALIGN_TRAP_EN.
module pc_sequencer #(
  parameter int unsigned          WIDTH     = 16,
  parameter logic [WIDTH-1:0]     RESET_VEC = 16'h0000,
  parameter logic [WIDTH-1:0]     STEP      = 16'd2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_branch_valid,
  input  logic [WIDTH-1:0] i_branch_offset,
  input  logic             i_halt,
  input  logic             i_imem_ack,
  output logic             o_imem_req,
  output logic [WIDTH-1:0] o_imem_addr,
  output logic [WIDTH-1:0] o_pc,
  output logic [15:0]      o_fetch_count,
  output logic             o_halted,
  output logic             o_trap
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_STALL  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [15:0]      r_fetch_count;
  logic             r_req;
  logic             r_halted;
  logic             r_trap;
  logic [WIDTH-1:0] w_branch_target;
  logic [WIDTH-1:0] w_seq_target;

  // Both candidate next-PC values wrap modulo 2^WIDTH.
  assign w_branch_target = r_pc + i_branch_offset;
  assign w_seq_target    = r_pc + STEP;

  // Sequencer FSM; all outputs are registered here.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_VEC;
      r_fetch_count <= 16'd0;
      r_req         <= 1'b0;
      r_halted      <= 1'b0;
      r_trap        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
        end
        S_REQ: begin
          // Stall wins over ack: the handshake is withdrawn this cycle.
          if (i_stall) begin
            r_state <= S_STALL;
            r_req   <= 1'b0;
          end else if (i_imem_ack) begin
            r_fetch_count <= r_fetch_count + 16'd1;
            if (i_halt) begin
              r_state  <= S_HALTED;
              r_req    <= 1'b0;
              r_halted <= 1'b1;
            end else if (i_branch_valid) begin
`ifdef PC_ALIGN_TRAP_EN
              if (w_branch_target[0]) begin
                r_state  <= S_HALTED;
                r_req    <= 1'b0;
                r_halted <= 1'b1;
                r_trap   <= 1'b1;
              end else begin
                r_pc <= w_branch_target;
              end
`else
              r_pc <= w_branch_target;
`endif
            end else begin
              r_pc <= w_seq_target;
            end
          end else begin
            r_req <= 1'b1;
          end
        end
        S_STALL: begin
          if (!i_stall) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end else begin
            r_req <= 1'b0;
          end
        end
        S_HALTED: begin
          r_req    <= 1'b0;
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_req    = r_req;
  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_fetch_count = r_fetch_count;
  assign o_halted      = r_halted;
  assign o_trap        = r_trap;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: default-vector instance plus a wrap-around reset-vector instance.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  int          total = 0;
  int          bad   = 0;

  logic        reset0 = 1'b1, stall0 = 1'b0, bv0 = 1'b0, halt0 = 1'b0, ack0 = 1'b0;
  logic [15:0] off0 = 16'h0000;
  logic        req0, halted0, trap0;
  logic [15:0] addr0, pc0, cnt0;

  logic        reset1 = 1'b1, stall1 = 1'b0, bv1 = 1'b0, halt1 = 1'b0, ack1 = 1'b0;
  logic [15:0] off1 = 16'h0000;
  logic        req1, halted1, trap1;
  logic [15:0] addr1, pc1, cnt1;

  always #5 clk = ~clk;

  pc_sequencer #(.WIDTH(16), .RESET_VEC(16'h0000), .STEP(16'd2)) dut0 (
    .i_clk(clk), .i_reset(reset0), .i_stall(stall0), .i_branch_valid(bv0),
    .i_branch_offset(off0), .i_halt(halt0), .i_imem_ack(ack0),
    .o_imem_req(req0), .o_imem_addr(addr0), .o_pc(pc0), .o_fetch_count(cnt0),
    .o_halted(halted0), .o_trap(trap0)
  );

  pc_sequencer #(.WIDTH(16), .RESET_VEC(16'hFFFE), .STEP(16'd2)) dut1 (
    .i_clk(clk), .i_reset(reset1), .i_stall(stall1), .i_branch_valid(bv1),
    .i_branch_offset(off1), .i_halt(halt1), .i_imem_ack(ack1),
    .o_imem_req(req1), .o_imem_addr(addr1), .o_pc(pc1), .o_fetch_count(cnt1),
    .o_halted(halted1), .o_trap(trap1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the full observable state of dut0 in one call.
  task automatic chk0(input string tag, input logic [15:0] e_pc, input logic e_req,
                      input logic [15:0] e_cnt, input logic e_halted, input logic e_trap);
    check({tag, ".pc"},     pc0,             e_pc);
    check({tag, ".addr"},   addr0,           e_pc);
    check({tag, ".req"},    {15'd0, req0},   {15'd0, e_req});
    check({tag, ".cnt"},    cnt0,            e_cnt);
    check({tag, ".halted"}, {15'd0, halted0}, {15'd0, e_halted});
    check({tag, ".trap"},   {15'd0, trap0},  {15'd0, e_trap});
  endtask

  task automatic chk1(input string tag, input logic [15:0] e_pc, input logic e_req,
                      input logic [15:0] e_cnt, input logic e_halted);
    check({tag, ".pc"},     pc1,              e_pc);
    check({tag, ".addr"},   addr1,            e_pc);
    check({tag, ".req"},    {15'd0, req1},    {15'd0, e_req});
    check({tag, ".cnt"},    cnt1,             e_cnt);
    check({tag, ".halted"}, {15'd0, halted1}, {15'd0, e_halted});
    check({tag, ".trap"},   {15'd0, trap1},   16'h0000);
  endtask

  initial begin
    // Reset and sequential fetch
    step(); step();
    chk0("rst", 16'h0000, 1'b0, 16'd0, 1'b0, 1'b0);
    reset0 = 1'b0; ack0 = 1'b1;
    chk0("idle", 16'h0000, 1'b0, 16'd0, 1'b0, 1'b0);
    step(); chk0("req0", 16'h0000, 1'b1, 16'd0, 1'b0, 1'b0);
    step(); chk0("seq1", 16'h0002, 1'b1, 16'd1, 1'b0, 1'b0);
    step(); chk0("seq2", 16'h0004, 1'b1, 16'd2, 1'b0, 1'b0);
    step(); chk0("seq3", 16'h0006, 1'b1, 16'd3, 1'b0, 1'b0);

    // Backward branch 0006 + FFFA -> 0000
    bv0 = 1'b1; off0 = 16'hFFFA;
    step(); chk0("br_back", 16'h0000, 1'b1, 16'd4, 1'b0, 1'b0);
    bv0 = 1'b0;
    step(); chk0("seq5", 16'h0002, 1'b1, 16'd5, 1'b0, 1'b0);
    step(); chk0("seq6", 16'h0004, 1'b1, 16'd6, 1'b0, 1'b0);

    // Stall with ack held high: nothing accepted
    stall0 = 1'b1;
    step(); chk0("stall1", 16'h0004, 1'b0, 16'd6, 1'b0, 1'b0);
    step(); chk0("stall2", 16'h0004, 1'b0, 16'd6, 1'b0, 1'b0);
    step(); chk0("stall3", 16'h0004, 1'b0, 16'd6, 1'b0, 1'b0);
    stall0 = 1'b0;
    step(); chk0("rereq", 16'h0004, 1'b1, 16'd6, 1'b0, 1'b0);
    step(); chk0("seq7", 16'h0006, 1'b1, 16'd7, 1'b0, 1'b0);

    // Forward branch 0006 + 0010 -> 0016
    bv0 = 1'b1; off0 = 16'h0010;
    step(); chk0("br_fwd", 16'h0016, 1'b1, 16'd8, 1'b0, 1'b0);
    bv0 = 1'b0; ack0 = 1'b0;
    step(); chk0("noack", 16'h0016, 1'b1, 16'd8, 1'b0, 1'b0);
    // Branch without ack is ignored
    bv0 = 1'b1; off0 = 16'h0100;
    step(); chk0("br_noack", 16'h0016, 1'b1, 16'd8, 1'b0, 1'b0);
    ack0 = 1'b1; off0 = 16'hFFF4;
    step(); chk0("br_to_a", 16'h000A, 1'b1, 16'd9, 1'b0, 1'b0);
    bv0 = 1'b0; ack0 = 1'b0;
    step(); chk0("hold_a", 16'h000A, 1'b1, 16'd9, 1'b0, 1'b0);

    // Reset mid-request
    reset0 = 1'b1;
    step(); chk0("rst_mid", 16'h0000, 1'b0, 16'd0, 1'b0, 1'b0);
    reset0 = 1'b0;
    step(); chk0("req_again", 16'h0000, 1'b1, 16'd0, 1'b0, 1'b0);
    ack0 = 1'b1;
    step(); chk0("seq_r1", 16'h0002, 1'b1, 16'd1, 1'b0, 1'b0);

    // Odd branch target 0002 + 0001
    bv0 = 1'b1; off0 = 16'h0001;
    step();
`ifdef PC_ALIGN_TRAP_EN
    chk0("trap", 16'h0002, 1'b0, 16'd2, 1'b1, 1'b1);
    step(); chk0("trap_sticky", 16'h0002, 1'b0, 16'd2, 1'b1, 1'b1);
`else
    chk0("odd_br", 16'h0003, 1'b1, 16'd2, 1'b0, 1'b0);
    bv0 = 1'b0;
    step(); chk0("odd_seq", 16'h0005, 1'b1, 16'd3, 1'b0, 1'b0);
`endif

    // Wrap-around reset vector instance
    chk1("rst1", 16'hFFFE, 1'b0, 16'd0, 1'b0);
    reset1 = 1'b0; ack1 = 1'b1;
    step(); chk1("w_req", 16'hFFFE, 1'b1, 16'd0, 1'b0);
    step(); chk1("w_wrap", 16'h0000, 1'b1, 16'd1, 1'b0);
    step(); chk1("w_seq", 16'h0002, 1'b1, 16'd2, 1'b0);
    halt1 = 1'b1; bv1 = 1'b1; off1 = 16'h0100;
    step(); chk1("halt", 16'h0002, 1'b0, 16'd3, 1'b1);
    halt1 = 1'b0; stall1 = 1'b0;
    step(); chk1("halt_hold", 16'h0002, 1'b0, 16'd3, 1'b1);
    reset1 = 1'b1;
    step(); chk1("halt_rst", 16'hFFFE, 1'b0, 16'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the single-cycle processor datapath. It owns the 16-bit PC register and drives the instruction-memory fetch handshake. It selects each next PC as sequential (PC+STEP), branch (PC+offset) or hold, and performs those additions internally with modulo-2^16 wrap. It sits between the control unit (stall, branch, halt) and instruction memory, and replaces free-running PC increment logic with a handshaked, stallable fetch sequence.

## Interface
- WIDTH, 16: PC and address width.
- RESET_VEC, 16'h0000: PC value loaded on reset.
- STEP, 16'd2: sequential increment (one 16-bit instruction).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  control-unit stall; freezes PC and withdraws the fetch request.
- branch_valid  input  1  take branch on the current fetch.
- branch_offset  input  WIDTH  two's-complement offset added to the current PC.
- halt  input  1  stop fetching after the current fetch completes.
- imem_ack  input  1  instruction memory accepts the request this cycle.
- imem_req  output  1  fetch request.
- imem_addr  output  WIDTH  fetch address; always equal to pc.
- pc  output  WIDTH  current program counter.
- fetch_count  output  16  number of accepted fetches; wraps.
- halted  output  1  high in HALTED.
- trap  output  1  misaligned-branch trap (see Configuration).

## Operation
- States: IDLE, REQ, STALL, HALTED.
- Reset (synchronous): pc=RESET_VEC, state=IDLE, imem_req=0, fetch_count=0, halted=0, trap=0.
- IDLE: imem_req=0. Moves to REQ on the next cycle unconditionally.
- REQ: imem_req=1, imem_addr=pc.
  - Acceptance: a fetch is accepted when imem_req & imem_ack & !stall.
  - On acceptance: fetch_count increments, and the next state is chosen by priority, highest first:
    - halt: pc is unchanged and the state moves to HALTED.
    - branch_valid: pc <= pc + branch_offset.
    - otherwise: pc <= pc + STEP.
  - No acceptance with stall=0: stay in REQ and hold pc, keeping the request asserted.
- stall=1 in REQ overrides imem_ack in the same cycle: the ack is dropped, pc holds, fetch_count holds, and the state moves to STALL.
- STALL: imem_req=0, pc holds. Returns to REQ on the first cycle with stall=0, re-issuing the same address.
- HALTED: imem_req=0, halted=1, all inputs ignored. Only reset exits.
- branch_valid and halt are sampled only on an accepted fetch and are ignored otherwise.
- Arithmetic: all additions are WIDTH bits with carry discarded. 16'hFFFE+2 gives 16'h0000; 16'h0004+16'hFFFA gives 16'hFFFE.
- fetch_count wraps from 16'hFFFF to 0.
- reset asserted in any state, including mid-request, takes effect at the next edge. No request survives reset.

## Timing
- Minimum of one cycle per fetch when imem_ack is high combinationally in the request cycle.
- The new pc and imem_addr are visible in the cycle after the accepting edge.
- First request is asserted in cycle 2 after reset deassertion: one reset-release edge, then IDLE.
- The leave-STALL decision is registered, so the first re-request appears one cycle after stall falls.
- All outputs are registered or decoded from state/pc only. There are no combinational input-to-output paths.

## Configuration
- PC_ALIGN_TRAP_EN defined: an accepted branch whose target (pc+branch_offset) has bit0=1 does not update pc. The state moves to HALTED with trap=1 and halted=1. trap is sticky until reset, and fetch_count still increments for that fetch.
- PC_ALIGN_TRAP_EN undefined: the target is loaded as computed, including odd values, and trap is tied to 0.

## Test plan
- Reset, then ack held high for 4 cycles -> imem_addr sequence 0000,0002,0004,0006 and fetch_count=4; imem_req=0 in IDLE.
- pc=0006, ack with branch_valid=1, offset=16'hFFFA -> pc=0000 next cycle. Same setup with offset=16'h0010 -> pc=0016.
- pc=0004 in REQ, stall=1 together with ack=1 for 3 cycles, then stall=0 -> pc stays 0004 and fetch_count is unchanged. imem_req=0 during stall and re-asserts with addr 0004 one cycle after stall falls.
- RESET_VEC=16'hFFFE, ack high -> addresses FFFE,0000,0002 (wrap). Ack with halt=1 and branch_valid=1 -> pc unchanged, halted=1, imem_req=0 thereafter.
- With PC_ALIGN_TRAP_EN: pc=0002, branch with offset=1 -> trap=1, halted=1, pc=0002. Without the macro: same stimulus -> pc=0003, trap=0.
- reset pulsed while in REQ with ack low at pc=000A -> next cycle pc=RESET_VEC, imem_req=0, fetch_count=0.
